silife_step_scheduler: RTL
==========================

Name: silife_step_scheduler

Overview:
Generation sequencer for the silife cell matrix. It issues one-cycle step pulses to the matrix enable input, either free-running at a programmable period or as single steps. Each step is held off while a bus access to the matrix is in flight and, optionally, until the display driver has finished a frame. It counts generations and stops free-run at a programmable limit. It sits between the control register file and the matrix, replacing the raw enable/clk_pulse path.

Parameters:
PERIOD_WIDTH, 16, width of the step period in clk cycles
GEN_WIDTH, 32, width of the generation counter and limit

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
i_run  input  1  level; 1 = free-run
i_step  input  1  one-cycle single-step request
i_period  input  PERIOD_WIDTH  cycles between free-run steps
i_gen_limit  input  GEN_WIDTH  free-run stop count; 0 = unlimited
i_clear_gen  input  1  one-cycle pulse; zeroes the generation count and limit flag
i_frame_sync  input  1  1 = steps also wait for a completed display frame
i_frame_done  input  1  one-cycle pulse from the display driver at end of frame
i_bus_busy  input  1  matrix bus access in progress; blocks steps
o_step  output  1  one-cycle matrix enable pulse (registered)
o_generation  output  GEN_WIDTH  steps issued since reset or clear
o_running  output  1  free-run active
o_limit_hit  output  1  sticky; generation limit reached

Behaviour:
- Reset (reset=0, async): state IDLE; o_step=0, o_generation=0, o_running=0, o_limit_hit=0; timer=0; frame_seen=0; step_pending=0.
- States: IDLE, WAIT (timer counting), HOLD (timer expired, gated), FIRE (o_step=1 for exactly one cycle).
- Effective period N = max(i_period, 2). i_period is sampled whenever the timer loads.
- IDLE -> WAIT when i_run=1 and o_limit_hit=0. The timer loads N-1 and decrements each cycle.
- WAIT -> FIRE when timer==0 and the gate is open. WAIT -> HOLD when timer==0 and the gate is closed.
- Gate open = !i_bus_busy && (!i_frame_sync || frame_seen).
- HOLD -> FIRE on the first cycle the gate is sampled open.
- Unblocked free-run: o_step asserts every N cycles. The first o_step asserts N cycles after i_run is first sampled high.
- FIRE -> WAIT (timer reloads) if still running; otherwise FIRE -> IDLE.
- Deferral does not accumulate. The period restarts at each FIRE, and there are never back-to-back catch-up steps.
- frame_seen is set by i_frame_done and cleared in the FIRE cycle. If i_frame_done arrives in the FIRE cycle, set wins.
- i_run sampled 0 in WAIT or HOLD -> IDLE next cycle, with no step. A FIRE already in progress completes.
- Single step:
  - i_step in IDLE with i_run=0 sets step_pending, then enters HOLD directly. The period is bypassed; the gate still applies.
  - i_step while running, or while step_pending=1, is ignored; steps are not queued.
  - Single steps ignore o_limit_hit.
- Generation counter: +1 in every FIRE cycle; wraps modulo 2^GEN_WIDTH.
- Limit: during free-run, if the incremented count equals a nonzero i_gen_limit, set o_limit_hit and go FIRE -> IDLE. Free-run then stays blocked until i_clear_gen.
- i_clear_gen: o_generation <= 0 and o_limit_hit <= 0. If it coincides with FIRE, clear wins (result 0, no limit check).
- o_running = 1 in WAIT, HOLD and FIRE when not step_pending.
- Reset asserted mid-HOLD or mid-FIRE: immediate return to reset values; the pending step is discarded.

Decomposition:
- Shared package silife_pkg holds:
  - the state encoding typedef (IDLE/WAIT/HOLD/FIRE)
  - default PERIOD_WIDTH and GEN_WIDTH constants
  - the minimum-period constant (2)
- One sub-module: silife_period_timer. It handles load N-1, decrement, and a one-cycle expire output, with async active-low reset.

Test Plan:
- Free-run, i_period=5, no blocking, i_run held high -> o_step pulses exactly every 5 cycles; o_generation = 1, 2, 3 … in step.
- i_period=0 and i_period=1 -> spacing is 2 cycles; o_step is never high on consecutive cycles.
- Free-run, i_period=4, i_bus_busy high for 7 cycles spanning expiry -> exactly one o_step, 1 cycle after busy drops; next step 4 cycles after that (no burst).
- i_frame_sync=1, i_period=3, i_frame_done every 10 cycles -> o_step only after each frame_done; one step per frame.
- i_gen_limit=3, i_run=1 -> 3 pulses, then o_limit_hit=1, o_running=0. i_clear_gen -> o_generation=0, and free-run resumes.
- i_run=0, i_step pulsed twice 1 cycle apart -> exactly one o_step. reset asserted during HOLD -> all outputs 0 and no step after release.

Source files
------------

// File: rtl/silife_step_scheduler_pkg.sv
// Shared types and constants for the silife generation step scheduler.
package silife_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_FIRE = 2'd3
    } sched_state_t;

    localparam int DEF_PERIOD_WIDTH = 16;
    localparam int DEF_GEN_WIDTH    = 32;

    // Shortest legal step period; guarantees o_step is never high two cycles running.
    localparam int MIN_PERIOD       = 2;

endpackage

// File: rtl/silife_step_scheduler_if.sv
// Control-side bundle between the register file and the step scheduler.
interface silife_step_scheduler_if #(
    parameter int PERIOD_WIDTH = 16,
    parameter int GEN_WIDTH    = 32
);
    logic                    i_run;
    logic                    i_step;
    logic [PERIOD_WIDTH-1:0] i_period;
    logic [GEN_WIDTH-1:0]    i_gen_limit;
    logic                    i_clear_gen;
    logic                    i_frame_sync;
    logic                    i_frame_done;
    logic                    i_bus_busy;
    logic                    o_step;
    logic [GEN_WIDTH-1:0]    o_generation;
    logic                    o_running;
    logic                    o_limit_hit;

    modport master (
        output i_run, i_step, i_period, i_gen_limit, i_clear_gen,
               i_frame_sync, i_frame_done, i_bus_busy,
        input  o_step, o_generation, o_running, o_limit_hit
    );

    modport slave (
        input  i_run, i_step, i_period, i_gen_limit, i_clear_gen,
               i_frame_sync, i_frame_done, i_bus_busy,
        output o_step, o_generation, o_running, o_limit_hit
    );
endinterface

// File: rtl/silife_step_scheduler_period_timer.sv
// Down-counter for the step period: load N-1, count to zero, flag one expiry cycle.
module silife_period_timer
    import silife_pkg::*;
#(
    parameter int PERIOD_WIDTH = DEF_PERIOD_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [PERIOD_WIDTH-1:0] load_val,
    output logic                    expire
);

    logic [PERIOD_WIDTH-1:0] count;
    logic                    armed;

    // armed drops after the expiry cycle so a parked zero count does not re-fire
    assign expire = armed && (count == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            armed <= 1'b0;
        end else if (load) begin
            count <= load_val;
            armed <= 1'b1;
        end else begin
            if (count != '0)
                count <= count - 1'b1;
            if (expire)
                armed <= 1'b0;
        end
    end

endmodule

// File: rtl/silife_step_scheduler.sv
// Generation sequencer: paces one-cycle matrix step pulses, gated by bus and frame activity.
module silife_step_scheduler
    import silife_pkg::*;
#(
    parameter int PERIOD_WIDTH = DEF_PERIOD_WIDTH,
    parameter int GEN_WIDTH    = DEF_GEN_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    silife_step_scheduler_if.slave bus
);

    sched_state_t            state;
    sched_state_t            state_nx;
    logic                    step_pending;
    logic                    frame_seen;
    logic                    step_q;
    logic [GEN_WIDTH-1:0]    generation;
    logic                    limit_hit;

    logic                    timer_load;
    logic                    pend_set;
    logic                    timer_expire;
    logic                    gate_open;
    logic                    limit_now;
    logic [PERIOD_WIDTH-1:0] period_eff;
    logic [PERIOD_WIDTH-1:0] load_val;
    logic [GEN_WIDTH-1:0]    gen_inc;

    assign period_eff = (bus.i_period < PERIOD_WIDTH'(MIN_PERIOD)) ?
                        PERIOD_WIDTH'(MIN_PERIOD) : bus.i_period;
    assign load_val   = period_eff - 1'b1;

    assign gate_open  = !bus.i_bus_busy && (!bus.i_frame_sync || frame_seen);
    assign gen_inc    = generation + 1'b1;
    // A clear landing on the FIRE cycle wins, so the limit is not evaluated then.
    assign limit_now  = !step_pending && !bus.i_clear_gen &&
                        (bus.i_gen_limit != '0) && (gen_inc == bus.i_gen_limit);

    silife_period_timer #(
        .PERIOD_WIDTH(PERIOD_WIDTH)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (timer_load),
        .load_val(load_val),
        .expire  (timer_expire)
    );

    // The timer reloads on entry to FIRE so the FIRE cycle counts toward the next period.
    always_comb begin
        state_nx   = state;
        timer_load = 1'b0;
        pend_set   = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.i_run && !limit_hit) begin
                    state_nx   = S_WAIT;
                    timer_load = 1'b1;
                end else if (bus.i_step && !bus.i_run) begin
                    state_nx = S_HOLD;
                    pend_set = 1'b1;
                end
            end
            S_WAIT: begin
                if (!bus.i_run) begin
                    state_nx = S_IDLE;
                end else if (timer_expire) begin
                    if (gate_open) begin
                        state_nx   = S_FIRE;
                        timer_load = 1'b1;
                    end else begin
                        state_nx = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!step_pending && !bus.i_run) begin
                    state_nx = S_IDLE;
                end else if (gate_open) begin
                    state_nx   = S_FIRE;
                    timer_load = 1'b1;
                end
            end
            S_FIRE: begin
                if (!step_pending && bus.i_run && !limit_now)
                    state_nx = S_WAIT;
                else
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            step_pending <= 1'b0;
            frame_seen   <= 1'b0;
            step_q       <= 1'b0;
            generation   <= '0;
            limit_hit    <= 1'b0;
        end else begin
            state  <= state_nx;
            step_q <= (state_nx == S_FIRE);

            if (pend_set)
                step_pending <= 1'b1;
            else if (state == S_FIRE)
                step_pending <= 1'b0;

            if (bus.i_frame_done)
                frame_seen <= 1'b1;
            else if (state == S_FIRE)
                frame_seen <= 1'b0;

            if (bus.i_clear_gen) begin
                generation <= '0;
                limit_hit  <= 1'b0;
            end else if (state == S_FIRE) begin
                generation <= gen_inc;
                if (limit_now)
                    limit_hit <= 1'b1;
            end
        end
    end

    assign bus.o_step       = step_q;
    assign bus.o_generation = generation;
    assign bus.o_limit_hit  = limit_hit;
    assign bus.o_running    = (state != S_IDLE) && !step_pending;

endmodule
